regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the CPU integer register file: XLEN-bit × NREGS entries, two combinational read ports, one write port with data/set/clear modes.
- Adds write-to-read bypass, a per-register pending-write scoreboard for pipeline hazard detection, a pending-write counter and a sticky error flag.
- Sits between decode (issue/read) and writeback stages of the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, ≥2; ADDR_W = $clog2(NREGS) (localparam).
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy; 0 = register 0 is ordinary.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- WR_EN  in  1  write-port enable.
- WR_MODE  in  2  00 = write data_in, 01 = set to 1, 10 = clear to 0, 11 = illegal.
- write_select  in  ADDR_W  write index.
- data_in  in  XLEN  write data.
- ISSUE_EN  in  1  mark issue_select as pending write.
- issue_select  in  ADDR_W  register being claimed by an issued instruction.
- reg_1_select, reg_2_select  in  ADDR_W  read indices.
- reg_1, reg_2  out  XLEN  read data (combinational).
- reg_1_busy, reg_2_busy  out  1  read operand has an outstanding write.
- pending_count  out  ADDR_W+1  number of set scoreboard bits (registered).
- ERR  out  1  sticky illegal-write flag.
- ERR_CLR  in  1  clears ERR.

Behaviour:
- Reset (RESET_N low, asynchronous): all registers = 0, all busy bits = 0, pending_count = 0, ERR = 0. Reads during reset return 0, busy outputs 0. Reset mid-stream discards any pending write/issue of that cycle.
- Effective write (wv): WR_EN & WR_MODE != 11 & !(ZERO_REG & write_select == 0). Value wval = data_in / {{XLEN-1{0}},1} / 0 per mode.
- On rising edge with wv: registers[write_select] <= wval. Same-cycle write latency 0 to reads via bypass, 1 cycle to storage.
- Bypass: reg_n = wval if wv & write_select == reg_n_select, else registers[reg_n_select]. With ZERO_REG, index 0 always reads 0.
- Scoreboard, per edge: on WR_EN (any legal mode) busy[write_select] <= 0. On ISSUE_EN busy[issue_select] <= 1. Issue and writeback to the same index in one cycle leaves busy = 1 (issue wins). With ZERO_REG, issue to 0 is ignored.
- reg_n_busy = busy[reg_n_select] & !(wv & write_select == reg_n_select); the bypassed value resolves the hazard that cycle.
- pending_count: registered, equals the population count of busy after each edge; max NREGS (or NREGS-1 with ZERO_REG). Issue to an already-busy register does not increment; writeback to a non-busy register does not decrement.
- ERR: set on edge when WR_EN & WR_MODE == 11 (no register or busy change). ERR_CLR clears it. Simultaneous set and clear: set wins.
- A write to register 0 with ZERO_REG = 1 is silently dropped and is not an error.
- No $display or simulation-only output in RTL.

Test Plan:
- Reset, then read all indices -> reg_1/reg_2 = 0, busy = 0, pending_count = 0, ERR = 0.
- WR_EN, mode 00, write_select 5, data_in 0xDEADBEEF, reg_1_select 5 in the same cycle -> reg_1 = 0xDEADBEEF combinationally; after edge it is still 0xDEADBEEF with WR_EN low.
- Mode 01 to reg 7 then mode 10 to reg 7 -> reads 0x00000001 then 0x00000000. Any write to reg 0 (ZERO_REG = 1) -> reg 0 reads 0.
- ISSUE_EN to 3 and 9 -> pending_count = 2, reg_1_busy = 1 on sel 3. Writeback to 3 with reg_1_select 3 -> busy = 0 that cycle; count becomes 1 after the edge.
- Same cycle: ISSUE_EN to 4 and WR_EN to 4 -> after edge busy[4] = 1, register 4 = data_in. WR_MODE 11 -> ERR = 1, no register change. ERR_CLR with a simultaneous illegal write -> ERR stays 1.
- Drive RESET_N low between clock edges while registers and busy bits are populated -> outputs go to 0 immediately with no edge required.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle of the register file: write port, issue port,
// two read ports with hazard flags, pending counter and error flag.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int ADDR_W = $clog2(NREGS);

    logic              WR_EN;
    logic [1:0]        WR_MODE;
    logic [ADDR_W-1:0] write_select;
    logic [XLEN-1:0]   data_in;
    logic              ISSUE_EN;
    logic [ADDR_W-1:0] issue_select;
    logic [ADDR_W-1:0] reg_1_select;
    logic [ADDR_W-1:0] reg_2_select;
    logic [XLEN-1:0]   reg_1;
    logic [XLEN-1:0]   reg_2;
    logic              reg_1_busy;
    logic              reg_2_busy;
    logic [ADDR_W:0]   pending_count;
    logic              ERR;
    logic              ERR_CLR;

    modport master (
        output WR_EN, WR_MODE, write_select, data_in,
        output ISSUE_EN, issue_select, reg_1_select, reg_2_select, ERR_CLR,
        input  reg_1, reg_2, reg_1_busy, reg_2_busy, pending_count, ERR
    );

    modport slave (
        input  WR_EN, WR_MODE, write_select, data_in,
        input  ISSUE_EN, issue_select, reg_1_select, reg_2_select, ERR_CLR,
        output reg_1, reg_2, reg_1_busy, reg_2_busy, pending_count, ERR
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass, per-register pending-write
// scoreboard, registered pending counter and sticky illegal-write flag.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clock,
    input  logic                 RESET_N,
    regfile_scoreboard_if.slave  bus
);
    localparam int ADDR_W = $clog2(NREGS);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic              wr_legal;
    logic              wr_illegal;
    logic              wv;
    logic [XLEN-1:0]   wval;
    logic              hit_1, hit_2;
    logic              zero_1, zero_2;

    // Gating with RESET_N keeps the bypass path from leaking data while in reset.
    always_comb begin
        wr_legal   = bus.WR_EN && (bus.WR_MODE != 2'b11);
        wr_illegal = bus.WR_EN && (bus.WR_MODE == 2'b11);
        wv         = RESET_N && wr_legal &&
                     !(ZERO_REG && (bus.write_select == '0));
        case (bus.WR_MODE)
            2'b00:   wval = bus.data_in;
            2'b01:   wval = {{(XLEN-1){1'b0}}, 1'b1};
            default: wval = '0;
        endcase
    end

    always_comb begin
        hit_1  = wv && (bus.write_select == bus.reg_1_select);
        hit_2  = wv && (bus.write_select == bus.reg_2_select);
        zero_1 = ZERO_REG && (bus.reg_1_select == '0);
        zero_2 = ZERO_REG && (bus.reg_2_select == '0);

        bus.reg_1 = regs_q[bus.reg_1_select];
        if (hit_1)  bus.reg_1 = wval;
        if (zero_1) bus.reg_1 = '0;

        bus.reg_2 = regs_q[bus.reg_2_select];
        if (hit_2)  bus.reg_2 = wval;
        if (zero_2) bus.reg_2 = '0;

        bus.reg_1_busy = busy_q[bus.reg_1_select] && !hit_1;
        bus.reg_2_busy = busy_q[bus.reg_2_select] && !hit_2;
    end

    // Issue is applied after writeback so a same-index collision stays busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_legal)
            busy_d[bus.write_select] = 1'b0;
        if (bus.ISSUE_EN && !(ZERO_REG && (bus.issue_select == '0)))
            busy_d[bus.issue_select] = 1'b1;

        count_d = '0;
        for (int i = 0; i < NREGS; i++)
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};

        err_d = err_q;
        if (bus.ERR_CLR) err_d = 1'b0;
        if (wr_illegal)  err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wv) begin
            regs_q[bus.write_select] <= wval;
        end
    end

    always_ff @(posedge clock or negedge RESET_N) begin
        if (!RESET_N) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.pending_count = count_q;
    assign bus.ERR           = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: literal spot checks plus a per-cycle
// comparison against an array-based model of the register file rules.
module tb_regfile_scoreboard;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    bit   cmp_en;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) bus ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1)) dut (
        .clock   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: plain arrays updated by the architectural rules.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_err;

    logic [31:0] e_wval, e_r1, e_r2;
    logic        e_wv, e_b1, e_b2;
    logic [5:0]  e_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'h0;
                m_busy[i] <= 1'b0;
            end
            m_err <= 1'b0;
        end else begin
            if (bus.WR_EN && bus.WR_MODE != 2'b11) begin
                if (bus.write_select != 5'd0) m_regs[bus.write_select] <= e_wval;
                m_busy[bus.write_select] <= 1'b0;
            end
            if (bus.ISSUE_EN && bus.issue_select != 5'd0)
                m_busy[bus.issue_select] <= 1'b1;
            if (bus.WR_EN && bus.WR_MODE == 2'b11) m_err <= 1'b1;
            else if (bus.ERR_CLR)                  m_err <= 1'b0;
        end
    end

    always_comb begin
        e_wval = (bus.WR_MODE == 2'b00) ? bus.data_in :
                 (bus.WR_MODE == 2'b01) ? 32'h1 : 32'h0;
        e_wv   = rst_n && bus.WR_EN && bus.WR_MODE != 2'b11 && bus.write_select != 5'd0;
        e_r1 = (bus.reg_1_select == 5'd0) ? 32'h0 :
               (e_wv && bus.write_select == bus.reg_1_select) ? e_wval : m_regs[bus.reg_1_select];
        e_r2 = (bus.reg_2_select == 5'd0) ? 32'h0 :
               (e_wv && bus.write_select == bus.reg_2_select) ? e_wval : m_regs[bus.reg_2_select];
        e_b1 = m_busy[bus.reg_1_select] && !(e_wv && bus.write_select == bus.reg_1_select);
        e_b2 = m_busy[bus.reg_2_select] && !(e_wv && bus.write_select == bus.reg_2_select);
        e_cnt = 6'd0;
        for (int i = 0; i < 32; i++) e_cnt = e_cnt + {5'd0, m_busy[i]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("cmp reg_1", bus.reg_1, e_r1);
            chk("cmp reg_2", bus.reg_2, e_r2);
            chk("cmp reg_1_busy", {31'd0, bus.reg_1_busy}, {31'd0, e_b1});
            chk("cmp reg_2_busy", {31'd0, bus.reg_2_busy}, {31'd0, e_b2});
            chk("cmp pending_count", {26'd0, bus.pending_count}, {26'd0, e_cnt});
            chk("cmp ERR", {31'd0, bus.ERR}, {31'd0, m_err});
        end
    end

    task automatic idle();
        bus.WR_EN = 1'b0; bus.WR_MODE = 2'b00; bus.write_select = 5'd0;
        bus.data_in = 32'h0; bus.ISSUE_EN = 1'b0; bus.issue_select = 5'd0;
        bus.ERR_CLR = 1'b0;
    endtask

    task automatic wr(input logic [1:0] mode, input logic [4:0] sel, input logic [31:0] d);
        bus.WR_EN = 1'b1; bus.WR_MODE = mode; bus.write_select = sel; bus.data_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cmp_en = 1'b0;
        rst_n = 1'b0;
        idle();
        bus.reg_1_select = 5'd0; bus.reg_2_select = 5'd0;
        #2;
        for (int i = 0; i < 32; i++) begin
            bus.reg_1_select = 5'(i);
            bus.reg_2_select = 5'(31 - i);
            #1;
            chk("reset reg_1", bus.reg_1, 32'h0);
            chk("reset reg_2", bus.reg_2, 32'h0);
            chk("reset busy", {30'd0, bus.reg_1_busy, bus.reg_2_busy}, 32'h0);
        end
        chk("reset pending_count", {26'd0, bus.pending_count}, 32'h0);
        chk("reset ERR", {31'd0, bus.ERR}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // Bypass of a data write, then the stored value.
        wr(2'b00, 5'd5, 32'hDEADBEEF); bus.reg_1_select = 5'd5; #1;
        chk("bypass 5", bus.reg_1, 32'hDEADBEEF);
        step(); idle(); #1;
        chk("stored 5", bus.reg_1, 32'hDEADBEEF);

        wr(2'b01, 5'd7, 32'hFFFF0000); bus.reg_2_select = 5'd7; #1;
        chk("set 7 bypass", bus.reg_2, 32'h1);
        step(); idle(); #1;
        chk("set 7 stored", bus.reg_2, 32'h1);
        wr(2'b10, 5'd7, 32'hFFFFFFFF); #1;
        chk("clear 7 bypass", bus.reg_2, 32'h0);
        step(); idle(); #1;
        chk("clear 7 stored", bus.reg_2, 32'h0);

        wr(2'b00, 5'd0, 32'hFFFFFFFF); bus.reg_1_select = 5'd0; #1;
        chk("zero bypass", bus.reg_1, 32'h0);
        step(); idle(); #1;
        chk("zero stored", bus.reg_1, 32'h0);
        chk("zero write no ERR", {31'd0, bus.ERR}, 32'h0);

        // Scoreboard issue / writeback.
        bus.ISSUE_EN = 1'b1; bus.issue_select = 5'd3; step();
        bus.issue_select = 5'd9; step(); idle(); bus.reg_1_select = 5'd3; #1;
        chk("count after 2 issues", {26'd0, bus.pending_count}, 32'd2);
        chk("busy 3", {31'd0, bus.reg_1_busy}, 32'd1);
        wr(2'b00, 5'd3, 32'h00001234); #1;
        chk("writeback busy clear", {31'd0, bus.reg_1_busy}, 32'd0);
        chk("writeback bypass", bus.reg_1, 32'h00001234);
        chk("count before edge", {26'd0, bus.pending_count}, 32'd2);
        step(); idle(); #1;
        chk("count after writeback", {26'd0, bus.pending_count}, 32'd1);

        bus.ISSUE_EN = 1'b1; bus.issue_select = 5'd4; wr(2'b00, 5'd4, 32'h0000A5A5);
        step(); idle(); bus.reg_1_select = 5'd4; #1;
        chk("issue wins busy 4", {31'd0, bus.reg_1_busy}, 32'd1);
        chk("issue+write data 4", bus.reg_1, 32'h0000A5A5);
        chk("count issue+write", {26'd0, bus.pending_count}, 32'd2);

        bus.ISSUE_EN = 1'b1; bus.issue_select = 5'd9; step(); idle(); #1;
        chk("reissue no increment", {26'd0, bus.pending_count}, 32'd2);
        wr(2'b00, 5'd5, 32'hCAFEF00D); step(); idle(); #1;
        chk("writeback idle no decrement", {26'd0, bus.pending_count}, 32'd2);
        bus.ISSUE_EN = 1'b1; bus.issue_select = 5'd0; step(); idle(); bus.reg_2_select = 5'd0; #1;
        chk("issue 0 ignored count", {26'd0, bus.pending_count}, 32'd2);
        chk("issue 0 ignored busy", {31'd0, bus.reg_2_busy}, 32'd0);

        // Illegal mode and sticky error.
        bus.reg_1_select = 5'd5;
        wr(2'b11, 5'd5, 32'h11111111); #1;
        chk("illegal no bypass", bus.reg_1, 32'hCAFEF00D);
        step(); idle(); #1;
        chk("ERR set", {31'd0, bus.ERR}, 32'd1);
        chk("illegal no change", bus.reg_1, 32'hCAFEF00D);
        wr(2'b11, 5'd5, 32'h0); bus.ERR_CLR = 1'b1; step(); idle(); #1;
        chk("set beats clear", {31'd0, bus.ERR}, 32'd1);
        bus.ERR_CLR = 1'b1; step(); idle(); #1;
        chk("ERR cleared", {31'd0, bus.ERR}, 32'd0);

        // Deterministic mixed traffic checked each cycle against the model.
        for (int i = 0; i < 48; i++) begin
            bus.WR_EN        = (i % 3) != 0;
            bus.WR_MODE      = 2'(i % 4);
            bus.write_select = 5'((i * 7) % 32);
            bus.data_in      = 32'h10000000 + 32'(i) * 32'h01010101;
            bus.ISSUE_EN     = (i % 2) == 1;
            bus.issue_select = 5'((i * 5) % 32);
            bus.reg_1_select = 5'((i * 3) % 32);
            bus.reg_2_select = 5'((i * 11 + 1) % 32);
            bus.ERR_CLR      = (i % 5) == 0;
            step();
        end
        idle();

        // Asynchronous reset between edges with populated state.
        wr(2'b11, 5'd1, 32'h0); bus.ISSUE_EN = 1'b1; bus.issue_select = 5'd6; step();
        idle(); wr(2'b00, 5'd5, 32'h55AA55AA); step();
        idle(); bus.reg_1_select = 5'd5; bus.reg_2_select = 5'd6;
        wr(2'b00, 5'd5, 32'h00000077); #1;
        chk("pre-reset bypass", bus.reg_1, 32'h00000077);
        chk("pre-reset busy 6", {31'd0, bus.reg_2_busy}, 32'd1);
        chk("pre-reset ERR", {31'd0, bus.ERR}, 32'd1);
        #1 rst_n = 1'b0; #1;
        chk("async reg_1", bus.reg_1, 32'h0);
        chk("async reg_2", bus.reg_2, 32'h0);
        chk("async busy", {30'd0, bus.reg_1_busy, bus.reg_2_busy}, 32'h0);
        chk("async count", {26'd0, bus.pending_count}, 32'h0);
        chk("async ERR", {31'd0, bus.ERR}, 32'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step(); #1;
        chk("post-reset reg 5", bus.reg_1, 32'h0);
        chk("post-reset count", {26'd0, bus.pending_count}, 32'h0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
